// File: rtl/pipe_stage_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_stage_reg                                                             |
// | Valid/ready stage register for a PC + instruction pair; flush inserts a    |
// | NOP bubble. Define PIPE_STAGE_REG_SKID_EN to add a skid entry and a        |
// | registered in_ready.                                                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pipe_stage_reg #(
  parameter int unsigned         PC_W         = 16,
  parameter int unsigned         INSTR_W      = 16,
  parameter logic [INSTR_W-1:0]  BUBBLE_INSTR = 16'hC0E0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [PC_W-1:0]      main_pc_q, main_pc_d;
  logic [INSTR_W-1:0]   main_instr_q, main_instr_d;
  logic                 in_fire_w;

`ifdef PIPE_STAGE_REG_SKID_EN
  logic [PC_W-1:0]      skid_pc_q, skid_pc_d;
  logic [INSTR_W-1:0]   skid_instr_q, skid_instr_d;
  logic                 in_ready_q;

  assign in_ready = in_ready_q;
`else
  assign in_ready = (state_q == ST_EMPTY) | out_ready;
`endif

  assign in_fire_w = in_valid & in_ready;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_pc    = main_pc_q;
  assign out_instr = main_instr_q;

  always_comb begin
    state_d      = state_q;
    main_pc_d    = main_pc_q;
    main_instr_d = main_instr_q;
`ifdef PIPE_STAGE_REG_SKID_EN
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
`endif

    case (state_q)
      ST_EMPTY: begin
        if (in_fire_w) begin
          state_d      = ST_FULL;
          main_pc_d    = in_pc;
          main_instr_d = in_instr;
        end
      end

      ST_FULL: begin
        if (in_fire_w && out_ready) begin
          main_pc_d    = in_pc;
          main_instr_d = in_instr;
        end
`ifdef PIPE_STAGE_REG_SKID_EN
        else if (in_fire_w) begin
          state_d      = ST_SKID;
          skid_pc_d    = in_pc;
          skid_instr_d = in_instr;
        end
`endif
        else if (out_ready) begin
          state_d      = ST_EMPTY;
          main_pc_d    = '0;
          main_instr_d = BUBBLE_INSTR;
        end
      end

`ifdef PIPE_STAGE_REG_SKID_EN
      ST_SKID: begin
        if (out_ready) begin
          state_d      = ST_FULL;
          main_pc_d    = skid_pc_q;
          main_instr_d = skid_instr_q;
        end
      end
`endif

      default: begin
        state_d      = ST_EMPTY;
        main_pc_d    = '0;
        main_instr_d = BUBBLE_INSTR;
      end
    endcase

    // Flush wins over every transition; an accepted input is silently dropped.
    if (flush) begin
      state_d      = ST_EMPTY;
      main_pc_d    = '0;
      main_instr_d = BUBBLE_INSTR;
`ifdef PIPE_STAGE_REG_SKID_EN
      skid_pc_d    = '0;
      skid_instr_d = BUBBLE_INSTR;
`endif
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_EMPTY;
      main_pc_q    <= '0;
      main_instr_q <= BUBBLE_INSTR;
    end else begin
      state_q      <= state_d;
      main_pc_q    <= main_pc_d;
      main_instr_q <= main_instr_d;
    end
  end

`ifdef PIPE_STAGE_REG_SKID_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      skid_pc_q    <= '0;
      skid_instr_q <= BUBBLE_INSTR;
      in_ready_q   <= 1'b1;
    end else begin
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      in_ready_q   <= (state_d != ST_SKID);
    end
  end
`endif

endmodule
`default_nettype wire
